// File: rtl/imu_reader_if.sv
// SPI bus between the IMU reader (master) and the accelerometer (slave).
// Mode 3: sclk idles high, the sensor drives on falling edges, the reader samples on rising edges.
interface imu_reader_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/imu_reader.sv
// Periodic SPI burst reader for the accelerometer X/Y registers.
// data_valid is a one-cycle strobe with no ready: consumers capture data_x/data_y on it.
module imu_reader #(
  parameter int          CLK_DIV       = 4,
  parameter int          SAMPLE_PERIOD = 300000,
  parameter logic [7:0]  ADDR          = 8'h28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  imu_reader_if.master       bus,
  output logic signed [15:0] data_x,
  output logic signed [15:0] data_y,
  output logic               data_valid,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  localparam int              TW         = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);
  // Read with auto-increment starting at the X low byte.
  localparam logic [7:0]      CMD        = {2'b11, ADDR[5:0]};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    XFER     = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [7:0]      div_cnt;
  logic            sclk_hi;
  logic [5:0]      bit_cnt;
  logic [31:0]     rx;
  logic            pending;
  logic            enable_q;
  logic [TW-1:0]   timer;
  logic            div_last;
  logic            trigger;
  logic            cs_n, sclk, mosi;

  assign div_last  = (div_cnt == DIV_LAST);
  // enable is registered once, so the timer starts counting the cycle after it is seen.
  assign trigger   = enable_q && (timer == TIMER_LAST);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  assign bus.spi_cs_n = cs_n;
  assign bus.spi_sclk = sclk;
  assign bus.spi_mosi = mosi;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cs_n       = 1'b1;
    sclk       = 1'b1;
    mosi       = 1'b0;
    data_valid = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_n = CS_SETUP;
      end
      CS_SETUP: begin
        cs_n = 1'b0;
        if (div_last) state_n = XFER;
      end
      XFER: begin
        cs_n = 1'b0;
        sclk = sclk_hi;
        mosi = (bit_cnt < 6'd8) ? CMD[~bit_cnt[2:0]] : 1'b0;
        if (div_last && sclk_hi && (bit_cnt == 6'd39)) state_n = CS_HOLD;
      end
      CS_HOLD: begin
        cs_n = 1'b0;
        if (div_last) state_n = DONE;
      end
      DONE: begin
        data_valid = 1'b1;
        state_n    = (pending || trigger) ? CS_SETUP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= 8'd0;
      sclk_hi  <= 1'b0;
      bit_cnt  <= 6'd0;
      rx       <= 32'd0;
      pending  <= 1'b0;
      enable_q <= 1'b0;
      timer    <= '0;
      data_x   <= 16'sd0;
      data_y   <= 16'sd0;
    end else begin
      enable_q <= enable;
      if (enable_q) timer <= (timer == TIMER_LAST) ? '0 : timer + TW'(1);

      // A single overrun is remembered; DONE consumes it by starting the next burst.
      if (state == DONE)                   pending <= 1'b0;
      else if (trigger && (state != IDLE)) pending <= 1'b1;

      if ((state == CS_SETUP) || (state == XFER) || (state == CS_HOLD))
        div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
      else
        div_cnt <= 8'd0;

      if (state == XFER) begin
        if (div_last) begin
          if (sclk_hi) begin
            sclk_hi <= 1'b0;
            bit_cnt <= bit_cnt + 6'd1;
          end else begin
            sclk_hi <= 1'b1;
            if (bit_cnt >= 6'd8) rx <= {rx[30:0], bus.spi_miso};
          end
        end
      end else begin
        sclk_hi <= 1'b0;
        bit_cnt <= 6'd0;
      end

      // rx holds XL, XH, YL, YH from MSB down; outputs change only here.
      if ((state == CS_HOLD) && div_last) begin
        data_x <= {rx[23:16], rx[31:24]};
        data_y <= {rx[7:0], rx[15:8]};
      end
    end
  end

endmodule

// File: tb/tb_imu_reader.sv
// Directed bench for imu_reader: reset, timing, data decode, overrun chaining and abort-by-reset.
module tb_imu_reader;

  localparam int CLK_DIV  = 2;
  localparam int PERIOD_A = 200;
  localparam int PERIOD_B = 50;
  localparam int XFER_LAT = 82 * CLK_DIV;

  logic        clk, reset, enable_a, enable_b;
  logic [15:0] x_a, y_a, x_b, y_b;
  logic        valid_a, busy_a, valid_b, busy_b;
  logic [2:0]  st_a, st_b;

  imu_reader_if if_a ();
  imu_reader_if if_b ();

  imu_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD_A)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .bus(if_a),
    .data_x(x_a), .data_y(y_a), .data_valid(valid_a), .busy(busy_a), .state_dbg(st_a)
  );

  imu_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD_B)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .bus(if_b),
    .data_x(x_b), .data_y(y_b), .data_valid(valid_b), .busy(busy_b), .state_dbg(st_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int r_base = 0;

  // sensor models: bytes {XL, XH, YL, YH}, shifted out MSB-first on falling sclk
  logic [31:0] sens_a, sens_b;
  logic [39:0] tx_a, tx_b;

  always @(negedge if_a.spi_cs_n or negedge if_a.spi_sclk) begin
    if (if_a.spi_sclk == 1'b0) begin
      if_a.spi_miso <= tx_a[39];
      tx_a <= {tx_a[38:0], 1'b0};
    end else begin
      tx_a <= {8'h00, sens_a};
      if_a.spi_miso <= 1'b0;
    end
  end

  always @(negedge if_b.spi_cs_n or negedge if_b.spi_sclk) begin
    if (if_b.spi_sclk == 1'b0) begin
      if_b.spi_miso <= tx_b[39];
      tx_b <= {tx_b[38:0], 1'b0};
    end else begin
      tx_b <= {8'h00, sens_b};
      if_b.spi_miso <= 1'b0;
    end
  end

  // bus activity monitors
  logic [39:0] cap_a;
  int rise_tot_a = 0, sclk_falls_a = 0, falls_a = 0, falls_b = 0, vcnt_a = 0, vcnt_b = 0;

  always @(posedge if_a.spi_sclk) begin
    if (if_a.spi_cs_n == 1'b0) begin
      cap_a      <= {cap_a[38:0], if_a.spi_mosi};
      rise_tot_a <= rise_tot_a + 1;
    end
  end
  always @(negedge if_a.spi_sclk) sclk_falls_a <= sclk_falls_a + 1;
  always @(negedge if_a.spi_cs_n) falls_a <= falls_a + 1;
  always @(negedge if_b.spi_cs_n) falls_b <= falls_b + 1;
  always @(posedge clk) if (valid_a === 1'b1) vcnt_a <= vcnt_a + 1;
  always @(posedge clk) if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;

  // outputs may only change in a data_valid cycle (or under reset)
  int          hold_err = 0;
  logic        rs;
  logic [31:0] pa, pb;
  always begin
    @(posedge clk);
    rs = reset;
    #1;
    if (!rs && (valid_a !== 1'b1) && ({x_a, y_a} !== pa)) hold_err++;
    if (!rs && (valid_b !== 1'b1) && ({x_b, y_b} !== pb)) hold_err++;
    pa = {x_a, y_a};
    pb = {x_b, y_b};
  end

  // scoreboard
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] bytes;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return if_a.spi_cs_n == 1'b0;
      1:       return valid_a == 1'b1;
      2:       return if_b.spi_cs_n == 1'b0;
      3:       return valid_b == 1'b1;
      4:       return (rise_tot_a - r_base) >= 20;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int limit, input string name);
    int n;
    n = 0;
    while (!cond(sel) && (n < limit)) begin
      tick();
      n++;
    end
    if (!cond(sel)) begin
      checks++;
      failures++;
      $display("FAIL %s: event not seen within %0d cycles", name, limit);
    end
  endtask

  initial begin
    int t_en, t_fall, t_v, t_prev, f0, e0, v0, vb0, fb;
    logic [31:0] exp;

    vecs[0] = '{32'h341278F6, 16'h1234, 16'hF678};
    vecs[1] = '{32'h00000000, 16'h0000, 16'h0000};
    vecs[2] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{32'h0080FF7F, 16'h8000, 16'h7FFF};
    vecs[4] = '{32'h0100FEFF, 16'h0001, 16'hFFFE};

    reset    = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;
    sens_a   = vecs[0].bytes;
    sens_b   = 32'hCDAB0180;

    // reset values
    repeat (3) tick();
    chk("rst_cs_n",  32'(if_a.spi_cs_n), 1);
    chk("rst_sclk",  32'(if_a.spi_sclk), 1);
    chk("rst_mosi",  32'(if_a.spi_mosi), 0);
    chk("rst_data",  {x_a, y_a}, 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_busy",  32'(busy_a), 0);
    chk("rst_state", 32'(st_a), 0);
    chk("rst_b_cs_n", 32'(if_b.spi_cs_n), 1);
    chk("rst_b_busy", 32'(busy_b), 0);

    // disabled: no bus activity at all
    reset = 1'b0;
    f0 = falls_a; e0 = sclk_falls_a; v0 = vcnt_a;
    repeat (1000) tick();
    chk("idle_cs_falls",   falls_a - f0, 0);
    chk("idle_sclk_falls", sclk_falls_a - e0, 0);
    chk("idle_valids",     vcnt_a - v0, 0);
    chk("idle_cs_level",   32'(if_a.spi_cs_n), 1);

    // table-driven reads on dut_a
    enable_a = 1'b1;
    t_en = cyc;
    for (int i = 0; i < 5; i++) begin
      sens_a = vecs[i].bytes;
      exp_q.push_back({vecs[i].exp_x, vecs[i].exp_y});
      wait_until(0, 400, "wait_a_cs_fall");
      t_fall = cyc;
      r_base = rise_tot_a;
      if (i == 0) chk("first_trigger_latency", t_fall - t_en, PERIOD_A + 1);
      wait_until(1, 400, "wait_a_valid");
      t_v = cyc;
      chk("valid_latency",    t_v - t_fall, XFER_LAT);
      chk("cs_high_at_valid", 32'(if_a.spi_cs_n), 1);
      chk("busy_at_valid",    32'(busy_a), 1);
      chk("sclk_rises",       rise_tot_a - r_base, 40);
      chk("mosi_cmd",         32'(cap_a[39:32]), 32'hE8);
      chk("mosi_tail",        cap_a[31:0], 0);
      exp = exp_q.pop_front();
      chk("data_xy", {x_a, y_a}, exp);
      if (i == 0) chk("data_y_signed", int'($signed(y_a)), -2440);
      tick();
      chk("valid_one_cycle", 32'(valid_a), 0);
      chk("busy_low_after",  32'(busy_a), 0);
      chk("data_hold",       {x_a, y_a}, {vecs[i].exp_x, vecs[i].exp_y});
    end

    // overrun on dut_b: bursts chain through the pending flag
    enable_b = 1'b1;
    wait_until(2, 100, "wait_b_start");
    vb0 = vcnt_b;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_until(3, 400, "wait_b_valid");
      t_v = cyc;
      if (k > 0) chk("b2b_period", t_v - t_prev, XFER_LAT + 1);
      t_prev = t_v;
      chk("b_data", {x_b, y_b}, 32'hABCD8001);
      chk("b_cs_high_at_valid", 32'(if_b.spi_cs_n), 1);
      tick();
      chk("b_gap_one_cycle", 32'(if_b.spi_cs_n), 0);
      chk("b_valid_one_cycle", 32'(valid_b), 0);
      chk("b_busy_between", 32'(busy_b), 1);
    end

    // dropping enable mid-burst lets the burst finish, then everything stops
    enable_b = 1'b0;
    fb = falls_b;
    wait_until(3, 400, "wait_b_last_valid");
    chk("b_finish_latency", cyc - t_prev, XFER_LAT + 1);
    chk("b_finish_data", {x_b, y_b}, 32'hABCD8001);
    tick();
    chk("b_idle_after_disable", 32'(busy_b), 0);
    repeat (300) tick();
    chk("b_no_new_cs", falls_b - fb, 0);
    chk("b_valid_count", vcnt_b - vb0, 4);

    // reset at the 20th sclk rise aborts the burst
    wait_until(1, 400, "wait_a_valid_sync");
    wait_until(0, 400, "wait_a_cs_fall2");
    r_base = rise_tot_a;
    v0 = vcnt_a;
    wait_until(4, 200, "wait_a_20th_rise");
    reset = 1'b1;
    enable_a = 1'b0;
    tick();
    chk("abort_cs_n",  32'(if_a.spi_cs_n), 1);
    chk("abort_sclk",  32'(if_a.spi_sclk), 1);
    chk("abort_mosi",  32'(if_a.spi_mosi), 0);
    chk("abort_busy",  32'(busy_a), 0);
    chk("abort_state", 32'(st_a), 0);
    chk("abort_data",  {x_a, y_a}, 0);
    tick();
    reset = 1'b0;
    f0 = falls_a;
    repeat (300) tick();
    chk("abort_no_valid",   vcnt_a - v0, 0);
    chk("abort_no_cs",      falls_a - f0, 0);
    chk("abort_data_stays", {x_a, y_a}, 0);
    chk("no_partial_data",  hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
